imem_loader: RTL and testbench



---
 rtl/mips_pkg.sv | 28 ++
 rtl/byte_packer.sv | 46 ++++
 rtl/imem_loader.sv | 166 ++++++++++++++++
 tb/tb_imem_loader.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the boot-time instruction-memory
//                loader: state encoding, header length and byte/word widths.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int BYTE_W  = 8;
    localparam int WORD_W  = 32;
    localparam int HDR_LEN = 2;                  // header bytes carrying N
    localparam int CNT_W   = HDR_LEN * BYTE_W;   // width of the word count N

    typedef enum logic [2:0] {
        ST_CNT_HI = 3'd0,
        ST_CNT_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHK    = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/byte_packer.sv
// ============================================================================
//  Module      : byte_packer
//  Description : 8->32 big-endian packer. The first byte of a group lands in
//                bits [31:24]. word_valid_o is a combinational strobe on the
//                4th accepted byte, with word_o holding the complete word.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                byte_valid_i      - byte accepted this cycle
//                byte_i            - byte value
//                word_o            - assembled word (valid with strobe)
//                word_valid_o      - 4th byte of a word accepted this cycle
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module byte_packer
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o
);

    // Only the three earlier bytes need storage; the 4th is taken straight
    // from the input so the word is available in the handshake cycle.
    logic [WORD_W-BYTE_W-1:0] shift_q;
    logic [1:0]               cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= 2'd0;
        end else if (byte_valid_i) begin
            shift_q <= {shift_q[WORD_W-2*BYTE_W-1:0], byte_i};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

    assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);
    assign word_o       = {shift_q, byte_i};

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time instruction-memory writer. Receives a byte stream
//                (16-bit big-endian word count N, then 4*N big-endian data
//                bytes), writes the words to addresses 0..N-1 and holds the
//                MIPS core in reset until the image is complete.
//                Optional feature macro IMEM_LOADER_CHECKSUM_EN: one trailing
//                byte, the XOR of all stream bytes must be 0x00.
//  Parameters  : ADDR_W - instruction-memory word-address width
//  Ports       : clk, rst                 - clock, sync active-high reset
//                in_valid/in_ready/in_data- byte-stream handshake
//                imem_we/imem_addr/imem_wdata - one-cycle write per word
//                cpu_rst                  - core reset, released with done
//                done, err                - sticky status until rst
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam int CMP_W = CNT_W + 1;
    // Capacity 2^ADDR_W expressed in the comparison width.
    localparam logic [CMP_W-1:0] CAP = {{CNT_W{1'b0}}, 1'b1} << ADDR_W;

    loader_state_e      state_q, state_d;
    logic [CNT_W-1:0]   n_q;
    logic [ADDR_W:0]    wcnt_q;          // one extra bit: N = 2^ADDR_W fits
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [WORD_W-1:0]  wdata_q;
    logic               done_q;
    logic               err_q;

    logic               w_accept;
    logic [CNT_W-1:0]   w_n_full;
    logic               w_oversize;
    logic [ADDR_W:0]    w_wcnt_inc;
    logic               w_last;
    logic               w_word_valid;
    logic [WORD_W-1:0]  w_word;
    logic               w_done_set;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]  xor_q;
    logic               w_chk_ok;
    assign w_chk_ok = ((xor_q ^ in_data) == '0);
`endif

    assign w_accept   = in_valid && in_ready;
    assign w_n_full   = {n_q[CNT_W-1:BYTE_W], in_data};
    assign w_oversize = ({1'b0, w_n_full} > CAP);
    assign w_wcnt_inc = wcnt_q + 1'b1;
    assign w_last     = ({{(CMP_W-ADDR_W-1){1'b0}}, w_wcnt_inc} == {1'b0, n_q});

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .byte_valid_i (w_accept && (state_q == ST_DATA)),
        .byte_i       (in_data),
        .word_o       (w_word),
        .word_valid_o (w_word_valid)
    );

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            ST_CNT_HI: begin
                in_ready = 1'b1;
                if (w_accept) state_d = ST_CNT_LO;
            end
            ST_CNT_LO: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    if (w_n_full == '0)  state_d = ST_DONE;
                    else if (w_oversize) state_d = ST_ERR;
                    else                 state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                in_ready = 1'b1;
                if (w_word_valid && w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                in_ready = 1'b1;
                if (w_accept) state_d = w_chk_ok ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_CNT_HI;
        endcase
        if (rst) in_ready = 1'b0;
    end

    // Entering DONE from DATA coincides with the registered write of the
    // last word, so done is raised one cycle later (when already in DONE).
    // From CNT_LO (N = 0) or CHK it is raised immediately.
    assign w_done_set = ((state_d == ST_DONE) && (state_q != ST_DATA))
                      || (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CNT_HI;
            n_q     <= '0;
            wcnt_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= w_word_valid;
            if (w_accept && (state_q == ST_CNT_HI)) n_q[CNT_W-1:BYTE_W] <= in_data;
            if (w_accept && (state_q == ST_CNT_LO)) n_q[BYTE_W-1:0]     <= in_data;
            if (w_word_valid) begin
                addr_q  <= wcnt_q[ADDR_W-1:0];
                wdata_q <= w_word;
                wcnt_q  <= w_wcnt_inc;
            end
            if (w_done_set)           done_q <= 1'b1;
            if (state_d == ST_ERR)    err_q  <= 1'b1;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst)           xor_q <= '0;
        else if (w_accept) xor_q <= xor_q ^ in_data;
    end
`endif

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cpu_rst    = ~done_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none

module tb_imem_loader;

    typedef logic [7:0]  bq_t [$];
    typedef logic [31:0] wq_t [$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    int         sel = 0;   // 0: ADDR_W=10 instance, 1: ADDR_W=4 instance

    logic        r10, we10, cr10, dn10, er10;
    logic [9:0]  a10;
    logic [31:0] d10;
    logic        r4, we4, cr4, dn4, er4;
    logic [3:0]  a4;
    logic [31:0] d4;

    imem_loader #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r10), .in_data(in_data),
        .imem_we(we10), .imem_addr(a10), .imem_wdata(d10),
        .cpu_rst(cr10), .done(dn10), .err(er10));

    imem_loader #(.ADDR_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r4), .in_data(in_data),
        .imem_we(we4), .imem_addr(a4), .imem_wdata(d4),
        .cpu_rst(cr4), .done(dn4), .err(er4));

    always #5 clk = ~clk;

    logic        m_ready, m_we, m_cpu_rst, m_done, m_err;
    logic [9:0]  m_addr;
    logic [31:0] m_wdata;
    assign m_ready   = (sel != 0) ? r4   : r10;
    assign m_we      = (sel != 0) ? we4  : we10;
    assign m_cpu_rst = (sel != 0) ? cr4  : cr10;
    assign m_done    = (sel != 0) ? dn4  : dn10;
    assign m_err     = (sel != 0) ? er4  : er10;
    assign m_addr    = (sel != 0) ? {6'd0, a4} : a10;
    assign m_wdata   = (sel != 0) ? d4   : d10;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed activity of the selected instance
    int          wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          hs_q[$];
    int          dbl, inv, done_cyc, err_cyc;
    logic        prev_we;

    // Reference expectations
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_wcyc[$];
    bit          exp_done, exp_err;
    int          exp_at;

    int runs  = 0;
    int fails = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_we) begin
                wr_addr.push_back(int'(m_addr));
                wr_data.push_back(m_wdata);
                wr_cyc.push_back(cyc);
            end
            if (m_we && prev_we) dbl++;
            prev_we = m_we;
            if (m_done && done_cyc < 0) done_cyc = cyc;
            if (m_err && err_cyc < 0)   err_cyc  = cyc;
            if (m_cpu_rst !== !m_done)  inv++;
        end
    end

    task automatic clear_obs();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); hs_q.delete();
        dbl = 0; inv = 0; done_cyc = -1; err_cyc = -1; prev_we = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_obs();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (g) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (m_ready) begin
                hs_q.push_back(cyc);
                @(posedge clk); #1;
                break;
            end
            if (t >= 50) begin
                runs++; fails++;
                $display("FAIL handshake_timeout: byte %h not accepted, in_ready %b required 1", b, m_ready);
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_stream(input bq_t s, input int gap_max);
        foreach (s[i]) send_byte(s[i], gap_max);
    endtask

    task automatic run(input bq_t s, input int gap_max);
        do_reset();
        send_stream(s, gap_max);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic mk_stream(input wq_t w, output bq_t s);
        int n;
        logic [7:0] x;
        n = w.size();
        s = {};
        s.push_back(8'(n >> 8));
        s.push_back(8'(n));
        foreach (w[i])
            for (int k = 3; k >= 0; k--) s.push_back(8'(w[i] >> (8 * k)));
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (n != 0) begin
            x = 8'h00;
            foreach (s[j]) x ^= s[j];
            s.push_back(x);
        end
`endif
    endtask

    // Expected behaviour from the stream format and the recorded handshake
    // cycles: words land one cycle after their 4th byte, done one cycle later.
    task automatic model(input bq_t s, input int aw);
        int n;
        logic [7:0] x;
        exp_addr.delete(); exp_data.delete(); exp_wcyc.delete();
        exp_done = 0; exp_err = 0; exp_at = -1;
        x = 8'h00;
        n = int'(s[0]) * 256 + int'(s[1]);
        if (n == 0) begin
            exp_done = 1; exp_at = hs_q[1] + 1;
        end else if (n > (1 << aw)) begin
            exp_err = 1; exp_at = hs_q[1] + 1;
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(i);
                exp_data.push_back({s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
                exp_wcyc.push_back(hs_q[5+4*i] + 1);
            end
            exp_at = hs_q[1+4*n] + 2;
`ifdef IMEM_LOADER_CHECKSUM_EN
            foreach (s[k]) x ^= s[k];
            if (x == 8'h00) begin
                exp_done = 1;
                if (hs_q[2+4*n] + 1 > exp_at) exp_at = hs_q[2+4*n] + 1;
            end else begin
                exp_err = 1; exp_at = hs_q[2+4*n] + 1;
            end
`else
            exp_done = 1;
`endif
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        runs++; if (r10 !== 1'b0)   begin fails++; $display("FAIL rst_ready: got %b want 0", r10); end
        runs++; if (we10 !== 1'b0)  begin fails++; $display("FAIL rst_we: got %b want 0", we10); end
        runs++; if (a10 !== 10'd0)  begin fails++; $display("FAIL rst_addr: got %h want 0", a10); end
        runs++; if (d10 !== 32'd0)  begin fails++; $display("FAIL rst_wdata: got %h want 0", d10); end
        runs++; if (cr10 !== 1'b1)  begin fails++; $display("FAIL rst_cpu_rst: got %b want 1", cr10); end
        runs++; if (dn10 !== 1'b0 || er10 !== 1'b0) begin
            fails++; $display("FAIL rst_status: got done %b err %b want 0 0", dn10, er10); end
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        runs++; if (r10 !== 1'b1)   begin fails++; $display("FAIL rst_ready_after: got %b want 1", r10); end
    endtask

    task automatic test_basic();
        wq_t w; bq_t s;
        sel = 0;
        w = {32'h20080005, 32'hAC080000};
        mk_stream(w, s);
        run(s, 0);
        model(s, 10);
        runs++; if (wr_data.size() != 2) begin fails++; $display("FAIL basic_count: got %0d want 2", wr_data.size()); end
        for (int i = 0; i < 2 && i < wr_data.size(); i++) begin
            runs++; if (wr_data[i] !== w[i] || wr_addr[i] != i) begin
                fails++; $display("FAIL basic_write[%0d]: got @%0d %h want @%0d %h", i, wr_addr[i], wr_data[i], i, w[i]); end
            runs++; if (wr_cyc[i] != exp_wcyc[i]) begin
                fails++; $display("FAIL basic_wcyc[%0d]: got %0d want %0d", i, wr_cyc[i], exp_wcyc[i]); end
        end
        runs++; if (done_cyc != exp_at) begin fails++; $display("FAIL basic_done_cyc: got %0d want %0d", done_cyc, exp_at); end
        runs++; if (dn10 !== 1'b1 || cr10 !== 1'b0 || r10 !== 1'b0) begin
            fails++; $display("FAIL basic_final: got done %b cpu_rst %b ready %b want 1 0 0", dn10, cr10, r10); end
    endtask

    task automatic test_zero();
        bq_t s;
        sel = 0;
        s = {8'h00, 8'h00};
        run(s, 0);
        runs++; if (wr_data.size() != 0) begin fails++; $display("FAIL zero_writes: got %0d want 0", wr_data.size()); end
        runs++; if (done_cyc != hs_q[1] + 1) begin fails++; $display("FAIL zero_done_cyc: got %0d want %0d", done_cyc, hs_q[1] + 1); end
        runs++; if (cr10 !== 1'b0 || er10 !== 1'b0) begin
            fails++; $display("FAIL zero_status: got cpu_rst %b err %b want 0 0", cr10, er10); end
        in_valid = 1'b1; in_data = 8'h5A;
        repeat (3) begin
            @(negedge clk);
            runs++; if (r10 !== 1'b0) begin fails++; $display("FAIL zero_ready: got %b want 0", r10); end
        end
        in_valid = 1'b0;
        runs++; if (wr_data.size() != 0) begin fails++; $display("FAIL zero_late_writes: got %0d want 0", wr_data.size()); end
    endtask

    task automatic test_oversize();
        bq_t s;
        sel = 1;
        s = {8'h00, 8'h11};
        run(s, 0);
        runs++; if (err_cyc != hs_q[1] + 1) begin fails++; $display("FAIL over_err_cyc: got %0d want %0d", err_cyc, hs_q[1] + 1); end
        runs++; if (er4 !== 1'b1 || dn4 !== 1'b0 || cr4 !== 1'b1 || r4 !== 1'b0) begin
            fails++; $display("FAIL over_status: got err %b done %b cpu_rst %b ready %b want 1 0 1 0", er4, dn4, cr4, r4); end
        runs++; if (wr_data.size() != 0) begin fails++; $display("FAIL over_writes: got %0d want 0", wr_data.size()); end
    endtask

    task automatic test_full();
        wq_t w; bq_t s;
        sel = 1;
        for (int i = 0; i < 16; i++) w.push_back($urandom);
        mk_stream(w, s);
        run(s, 0);
        model(s, 4);
        runs++; if (wr_data.size() != 16) begin fails++; $display("FAIL full_count: got %0d want 16", wr_data.size()); end
        for (int i = 0; i < 16 && i < wr_data.size(); i++) begin
            runs++; if (wr_data[i] !== exp_data[i] || wr_addr[i] != exp_addr[i]) begin
                fails++; $display("FAIL full_write[%0d]: got @%0d %h want @%0d %h", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]); end
        end
        runs++; if (dn4 !== 1'b1 || er4 !== 1'b0 || done_cyc != exp_at) begin
            fails++; $display("FAIL full_done: got done %b err %b at %0d want 1 0 at %0d", dn4, er4, done_cyc, exp_at); end
    endtask

    task automatic test_gaps();
        wq_t w; bq_t s;
        int          ref_addr[$];
        logic [31:0] ref_data[$];
        sel = 0;
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        mk_stream(w, s);
        run(s, 0);
        ref_addr = wr_addr; ref_data = wr_data;
        run(s, 3);
        model(s, 10);
        runs++; if (wr_data.size() != 3 || ref_data.size() != 3) begin
            fails++; $display("FAIL gaps_count: got %0d/%0d want 3/3", wr_data.size(), ref_data.size()); end
        for (int i = 0; i < 3 && i < wr_data.size() && i < ref_data.size(); i++) begin
            runs++; if (wr_data[i] !== exp_data[i] || wr_addr[i] != exp_addr[i] ||
                        ref_data[i] !== wr_data[i] || ref_addr[i] != wr_addr[i]) begin
                fails++; $display("FAIL gaps_write[%0d]: got @%0d %h (gap-free @%0d %h) want @%0d %h",
                                  i, wr_addr[i], wr_data[i], ref_addr[i], ref_data[i], exp_addr[i], exp_data[i]); end
            runs++; if (wr_cyc[i] != exp_wcyc[i]) begin
                fails++; $display("FAIL gaps_wcyc[%0d]: got %0d want %0d", i, wr_cyc[i], exp_wcyc[i]); end
        end
        runs++; if (dbl != 0) begin fails++; $display("FAIL gaps_pulse: got %0d multi-cycle pulses want 0", dbl); end
        runs++; if (done_cyc != exp_at) begin fails++; $display("FAIL gaps_done_cyc: got %0d want %0d", done_cyc, exp_at); end
    endtask

    task automatic test_reset_midload();
        bq_t p, s; wq_t w;
        logic [31:0] first;
        sel = 0;
        do_reset();
        first = $urandom;
        p = {8'h00, 8'h02, first[31:24], first[23:16], first[15:8], first[7:0], 8'hDE, 8'hAD};
        send_stream(p, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        w.push_back($urandom);
        mk_stream(w, s);
        send_stream(s, 1);
        repeat (6) @(posedge clk);
        #1;
        runs++; if (wr_data.size() != 2) begin fails++; $display("FAIL midrst_count: got %0d want 2", wr_data.size()); end
        if (wr_data.size() >= 2) begin
            runs++; if (wr_addr[0] != 0 || wr_data[0] !== first) begin
                fails++; $display("FAIL midrst_first: got @%0d %h want @0 %h", wr_addr[0], wr_data[0], first); end
            runs++; if (wr_addr[1] != 0 || wr_data[1] !== w[0]) begin
                fails++; $display("FAIL midrst_new: got @%0d %h want @0 %h", wr_addr[1], wr_data[1], w[0]); end
            runs++; if (done_cyc <= wr_cyc[1]) begin
                fails++; $display("FAIL midrst_cpu_rst_hold: done at %0d, required after write at %0d", done_cyc, wr_cyc[1]); end
        end
        runs++; if (inv != 0 || dn10 !== 1'b1 || cr10 !== 1'b0) begin
            fails++; $display("FAIL midrst_status: got inv %0d done %b cpu_rst %b want 0 1 0", inv, dn10, cr10); end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        bq_t s;
        sel = 0;
        s = {8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        run(s, 0);
        runs++; if (dn10 !== 1'b1 || er10 !== 1'b0 || cr10 !== 1'b0) begin
            fails++; $display("FAIL chk_good: got done %b err %b cpu_rst %b want 1 0 0", dn10, er10, cr10); end
        runs++; if (done_cyc != hs_q[6] + 1) begin fails++; $display("FAIL chk_good_cyc: got %0d want %0d", done_cyc, hs_q[6] + 1); end
        s = {8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
        run(s, 0);
        runs++; if (er10 !== 1'b1 || dn10 !== 1'b0 || cr10 !== 1'b1 || r10 !== 1'b0) begin
            fails++; $display("FAIL chk_bad: got err %b done %b cpu_rst %b ready %b want 1 0 1 0", er10, dn10, cr10, r10); end
        runs++; if (wr_data.size() != 1 || wr_data[0] !== 32'h12345678) begin
            fails++; $display("FAIL chk_bad_write: got %0d writes, first %h want 1, 12345678", wr_data.size(), wr_data[0]); end
    endtask
`endif

    initial begin
        clear_obs();
        test_reset();
        test_basic();
        test_zero();
        test_oversize();
        test_full();
        test_gaps();
        test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", runs, fails);
        $finish;
    end

endmodule

`default_nettype wire
